// File: rtl/lcd_bus_sequencer_pkg.sv
// Shared types and constants for the LCD bus sequencer.
package lcd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } lcd_state_e;

  // Bit positions inside the core's LCD register word.
  localparam int LCD_ON_BIT   = 31;
  localparam int LCD_EN_BIT   = 10;
  localparam int LCD_RS_BIT   = 9;
  localparam int LCD_RW_BIT   = 8;
  localparam int LCD_DATA_MSB = 7;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } lcd_cmd_t;

  // Extract the RS/RW/DATA command fields from a raw LCD register word.
  function automatic lcd_cmd_t word_to_cmd(input logic [31:0] word);
    lcd_cmd_t cmd;
    cmd.rs   = word[LCD_RS_BIT];
    cmd.rw   = word[LCD_RW_BIT];
    cmd.data = word[LCD_DATA_MSB:0];
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_bus_sequencer_if.sv
// LCD register word in, timed HD44780 bus and status out.
interface lcd_bus_sequencer_if;
  logic [31:0] i_lcd_word;
  logic        o_lcd_on;
  logic        o_lcd_en;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic [7:0]  o_lcd_data;
  logic        o_busy;
  logic        o_overrun;

  // Core side: writes the LCD word, observes bus and status.
  modport master (
    output i_lcd_word,
    input  o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_busy, o_overrun
  );

  // Sequencer side.
  modport slave (
    input  i_lcd_word,
    output o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_busy, o_overrun
  );
endinterface

// File: rtl/lcd_bus_sequencer_cmd_buf.sv
// One-entry pending command buffer with sticky overrun flag.
module lcd_cmd_buf
  import lcd_seq_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_reset,
  input  logic     i_load,     // new request arriving while the sequencer is busy
  input  logic     i_take,     // sequencer consumes the pending entry this cycle
  input  lcd_cmd_t i_cmd,
  output lcd_cmd_t o_cmd,
  output logic     o_valid,
  output logic     o_overrun
);

  lcd_cmd_t cmd_q;
  logic     valid_q;
  logic     overrun_q;

  // Capture when empty or being drained in the same cycle; otherwise drop and flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cmd_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (i_load && (!valid_q || i_take)) begin
        cmd_q <= i_cmd;
      end
      valid_q <= i_load | (valid_q & ~i_take);
      if (i_load && valid_q && !i_take) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign o_cmd     = cmd_q;
  assign o_valid   = valid_q;
  assign o_overrun = overrun_q;

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Turns software EN toggles into HD44780-timed setup/pulse/hold/gap bus cycles.
module lcd_bus_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 12,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned GAP_CYC   = 2000
) (
  input logic          i_clk,
  input logic          i_reset,
  lcd_bus_sequencer_if.slave bus_if
);

  localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned MAX_ALL = (MAX_SP > MAX_HG) ? MAX_SP : MAX_HG;
  localparam int          CNT_W   = $clog2(MAX_ALL) + 1;

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lcd_cmd_t         act_q, act_d;
  logic             prev_en_q;
  logic             on_q;
  logic             en_q;

  logic     trig;
  logic     cnt_zero;
  logic     gap_done;
  lcd_cmd_t word_cmd;
  lcd_cmd_t pend_cmd;
  logic     pend_vld;
  logic     pend_load;
  logic     pend_take;
  logic     pend_overrun;
  logic     unused_word_bits;

  assign trig     = bus_if.i_lcd_word[LCD_EN_BIT] & ~prev_en_q;
  assign word_cmd = word_to_cmd(bus_if.i_lcd_word);
  assign cnt_zero = (cnt_q == '0);
  assign gap_done = (state_q == GAP) && cnt_zero;
  assign unused_word_bits = &{1'b0, bus_if.i_lcd_word[30:11]};

  // A request goes to the pending slot unless the FSM can accept it directly:
  // in IDLE, or on the last GAP cycle when nothing is already waiting.
  assign pend_load = trig && (state_q != IDLE) && !(gap_done && !pend_vld);

  // Next-state, counter reload and active-command selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_d     = act_q;
    pend_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
          act_d   = word_cmd;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_d = PULSE;
          cnt_d   = CNT_W'(PULSE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_d = GAP;
          cnt_d   = CNT_W'(GAP_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_zero) begin
          if (pend_vld) begin
            state_d   = SETUP;
            cnt_d     = CNT_W'(SETUP_CYC - 1);
            act_d     = pend_cmd;
            pend_take = 1'b1;
          end else if (trig) begin
            state_d = SETUP;
            cnt_d   = CNT_W'(SETUP_CYC - 1);
            act_d   = word_cmd;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, active command and registered bus outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      act_q     <= '0;
      prev_en_q <= 1'b1;
      on_q      <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      prev_en_q <= bus_if.i_lcd_word[LCD_EN_BIT];
      on_q      <= bus_if.i_lcd_word[LCD_ON_BIT];
      en_q      <= (state_d == PULSE);
    end
  end

  lcd_cmd_buf u_cmd_buf (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (pend_load),
    .i_take    (pend_take),
    .i_cmd     (word_cmd),
    .o_cmd     (pend_cmd),
    .o_valid   (pend_vld),
    .o_overrun (pend_overrun)
  );

  assign bus_if.o_lcd_on   = on_q;
  assign bus_if.o_lcd_en   = en_q;
  assign bus_if.o_lcd_rs   = act_q.rs;
  assign bus_if.o_lcd_rw   = act_q.rw;
  assign bus_if.o_lcd_data = act_q.data;
  assign bus_if.o_busy     = (state_q != IDLE) | pend_vld;
  assign bus_if.o_overrun  = pend_overrun;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Randomized + directed bench for lcd_bus_sequencer with a timeline reference model.
module tb_lcd_bus_sequencer;

  localparam int S = 2;
  localparam int P = 3;
  localparam int H = 2;
  localparam int G = 5;
  localparam int L = S + P + H + G;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_bus_sequencer_if bus();

  lcd_bus_sequencer #(
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .GAP_CYC(G)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus_if  (bus)
  );

  typedef struct {
    int         rise;
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } txn_t;

  txn_t sb_q[$];

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  // Reference model: each accepted command occupies cycles start+1 .. start+L.
  bit         m_act = 1'b0;
  int         m_start = 0;
  logic [9:0] m_cur = '0;
  bit         m_pend_v = 1'b0;
  logic [9:0] m_pend = '0;
  bit         m_ovr = 1'b0;
  bit         m_prev = 1'b1;

  logic       exp_on = 1'b0, exp_en = 1'b0, exp_busy = 1'b0, exp_ovr = 1'b0;
  logic       exp_rs = 1'b0, exp_rw = 1'b0;
  logic [7:0] exp_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else if (n_tot - n_pass < 40)
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc + 1, act, req);
  endtask

  task automatic start_cmd(input int t, input logic [9:0] c);
    txn_t x;
    m_act   = 1'b1;
    m_start = t;
    m_cur   = c;
    x.rise  = t + 1 + S;
    x.rs    = c[9];
    x.rw    = c[8];
    x.data  = c[7:0];
    sb_q.push_back(x);
  endtask

  // Advance the model by one cycle of input w, then derive outputs for the next cycle.
  task automatic model_step(input int t, input logic [31:0] w);
    bit trig;
    int ph;
    trig   = w[10] & ~m_prev;
    m_prev = w[10];
    if (m_act && t == m_start + L) begin
      if (m_pend_v) begin
        start_cmd(t, m_pend);
        m_pend_v = 1'b0;
        if (trig) begin
          m_pend   = w[9:0];
          m_pend_v = 1'b1;
        end
      end else if (trig) begin
        start_cmd(t, w[9:0]);
      end else begin
        m_act = 1'b0;
      end
    end else if (!m_act) begin
      if (trig) start_cmd(t, w[9:0]);
    end else if (trig) begin
      if (!m_pend_v) begin
        m_pend   = w[9:0];
        m_pend_v = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
    ph       = (t + 1) - m_start;
    exp_on   = w[31];
    exp_en   = m_act && ph >= S + 1 && ph <= S + P;
    exp_busy = (m_act && ph >= 1 && ph <= L) || m_pend_v;
    exp_ovr  = m_ovr;
    exp_rs   = m_cur[9];
    exp_rw   = m_cur[8];
    exp_data = m_cur[7:0];
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_pend_v = 1'b0; m_ovr = 1'b0; m_prev = 1'b1; m_cur = '0;
    exp_on = 1'b0; exp_en = 1'b0; exp_busy = 1'b0; exp_ovr = 1'b0;
    exp_rs = 1'b0; exp_rw = 1'b0; exp_data = '0;
    sb_q.delete();
  endtask

  // Drive one cycle of stimulus on the falling edge.
  task automatic tick(input logic [31:0] w, input bit r);
    @(negedge clk);
    cyc++;
    bus.i_lcd_word = w;
    rst = r;
    if (r) model_reset();
    else   model_step(cyc, w);
  endtask

  task automatic hold(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) tick(w, 1'b0);
  endtask

  // Monitor: per-cycle status compare, and scoreboard pop on every EN rising edge.
  initial begin
    logic en_prev;
    txn_t x;
    en_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (chk_on) begin
        chk("lcd_en",   {31'b0, bus.o_lcd_en},   {31'b0, exp_en});
        chk("busy",     {31'b0, bus.o_busy},     {31'b0, exp_busy});
        chk("overrun",  {31'b0, bus.o_overrun},  {31'b0, exp_ovr});
        chk("lcd_on",   {31'b0, bus.o_lcd_on},   {31'b0, exp_on});
        chk("lcd_bus",  {22'b0, bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_data},
                        {22'b0, exp_rs, exp_rw, exp_data});
        if (bus.o_lcd_en && !en_prev) begin
          if (sb_q.size() == 0) begin
            n_tot++;
            $display("FAIL sb_underflow cyc=%0d actual=unexpected EN pulse required=none",
                     cyc + 1);
          end else begin
            x = sb_q.pop_front();
            $display("txn cyc=%0d rs=%b rw=%b data=0x%02h", cyc + 1,
                     bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_data);
            chk("en_rise_cyc", cyc + 1, x.rise);
            chk("txn_cmd", {22'b0, bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_data},
                           {22'b0, x.rs, x.rw, x.data});
          end
        end
      end
      en_prev = bus.o_lcd_en;
    end
  end

  // Stimulus: directed scenarios followed by random EN toggling and occasional resets.
  initial begin
    logic [31:0] w;
    bus.i_lcd_word = '0;
    for (int i = 0; i < 3; i++) tick(32'h0, 1'b1);
    chk_on = 1'b1;
    hold(32'h0, 2);

    // Single command with ON bit.
    hold(32'h8000_0438, 15);
    hold(32'h8000_0038, 2);

    // Second request during PULSE of the first: queued, no overrun.
    hold(32'h8000_0438, 3);
    hold(32'h8000_0038, 1);
    hold(32'h0000_0641, 30);
    hold(32'h0000_0041, 2);

    // Three requests within one command: third dropped, overrun sticks.
    hold(32'h0000_0411, 2);
    hold(32'h0000_0011, 1);
    hold(32'h0000_0622, 2);
    hold(32'h0000_0022, 1);
    hold(32'h0000_0533, 40);
    hold(32'h0000_0033, 5);
    tick(32'h0, 1'b1);
    hold(32'h0, 2);

    // Pending plus new request on the last GAP cycle.
    hold(32'h0000_04A1, 2);
    hold(32'h0000_00A1, 1);
    hold(32'h0000_06B2, 8);
    hold(32'h0000_00B2, 1);
    hold(32'h0000_05C3, 40);
    hold(32'h0000_00C3, 2);

    // Reset during PULSE with EN held high across reset release.
    hold(32'h8000_04D4, 3);
    tick(32'h8000_04D4, 1'b1);
    tick(32'h8000_04D4, 1'b1);
    hold(32'h8000_04D4, 10);
    hold(32'h0, 2);

    // RS/DATA changes while EN stays high mid-command.
    hold(32'h0000_0438, 4);
    hold(32'h0000_07FF, 20);
    hold(32'h0, 2);

    // Random traffic.
    w = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) w[10] = ~w[10];
      if ($urandom_range(0, 1) == 0) w[9:0] = 10'($urandom);
      if ($urandom_range(0, 15) == 0) w[31] = ~w[31];
      tick(w, $urandom_range(0, 499) == 0);
    end
    w[10] = 1'b0;
    hold(w, 3 * L);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
